// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes and the
// decoded-instruction record that travels through the decode stage.
package rv32_pkg;

   // Major opcodes (instr[6:0]) of the base integer ISA
   localparam logic [6:0] OPC_OP_IMM   = 7'h13;
   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] OPC_LOAD     = 7'h03;
   localparam logic [6:0] OPC_STORE    = 7'h23;
   localparam logic [6:0] OPC_BRANCH   = 7'h63;
   localparam logic [6:0] OPC_JAL      = 7'h6F;
   localparam logic [6:0] OPC_JALR     = 7'h67;
   localparam logic [6:0] OPC_LUI      = 7'h37;
   localparam logic [6:0] OPC_AUIPC    = 7'h17;
   localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
   localparam logic [6:0] OPC_SYSTEM   = 7'h73;

   // The two funct7 values the base ISA uses (normal and sub/sra variant)
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Instruction class tag; ILLEGAL must stay 0 so a reset record reads as illegal
   typedef enum logic [3:0] {
      CLS_ILLEGAL  = 4'd0,
      CLS_OP_IMM   = 4'd1,
      CLS_OP       = 4'd2,
      CLS_LOAD     = 4'd3,
      CLS_STORE    = 4'd4,
      CLS_BRANCH   = 4'd5,
      CLS_JAL      = 4'd6,
      CLS_JALR     = 4'd7,
      CLS_LUI      = 4'd8,
      CLS_AUIPC    = 4'd9,
      CLS_MISC_MEM = 4'd10,
      CLS_SYSTEM   = 4'd11
   } iclass_e;

   // Everything execute needs about one instruction, minus the valid bit
   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm12;
      logic [31:0] imm32;
      iclass_e     iclass;
      logic        illegal;
   } decoded_t;

   // Sign-extend a 12-bit immediate to 32 bits
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/rv32i_field_decode.sv
// Purely combinational RV32I field splitter: classifies the opcode, builds
// the format-specific immediate and flags encodings outside the base ISA.
// The pc field is left at zero; the stage that owns the PC fills it in.
module rv32i_field_decode
   import rv32_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [2:0] funct3;
   logic [6:0] funct7;

   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Split the raw fields, then pick class, immediate and legality by opcode
   always_comb begin
      dec         = '0;
      dec.opcode  = instr[6:0];
      dec.funct3  = funct3;
      dec.funct7  = funct7;
      dec.rd      = instr[11:7];
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.iclass  = CLS_ILLEGAL;
      dec.illegal = 1'b0;
      case (instr[6:0])
         OPC_OP_IMM: begin
            dec.iclass = CLS_OP_IMM;
            dec.imm12  = instr[31:20];
            dec.imm32  = sext12(instr[31:20]);
            if (funct3 == 3'b001 && funct7 != F7_ZERO) begin
               dec.illegal = 1'b1;
            end
            if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT) begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OP: begin
            dec.iclass = CLS_OP;
            if (funct7 != F7_ZERO && funct7 != F7_ALT) begin
               dec.illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            dec.iclass = CLS_LOAD;
            dec.imm12  = instr[31:20];
            dec.imm32  = sext12(instr[31:20]);
         end
         OPC_STORE: begin
            dec.iclass = CLS_STORE;
            dec.imm32  = sext12({instr[31:25], instr[11:7]});
         end
         OPC_BRANCH: begin
            dec.iclass = CLS_BRANCH;
            dec.imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_JAL: begin
            dec.iclass = CLS_JAL;
            dec.imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OPC_JALR: begin
            dec.iclass = CLS_JALR;
            dec.imm12  = instr[31:20];
            dec.imm32  = sext12(instr[31:20]);
            if (funct3 != 3'b000) begin
               dec.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.iclass = CLS_LUI;
            dec.imm32  = {instr[31:12], 12'h000};
         end
         OPC_AUIPC: begin
            dec.iclass = CLS_AUIPC;
            dec.imm32  = {instr[31:12], 12'h000};
         end
         OPC_MISC_MEM: begin
            dec.iclass = CLS_MISC_MEM;
         end
         OPC_SYSTEM: begin
            dec.iclass = CLS_SYSTEM;
            dec.imm12  = instr[31:20];
            dec.imm32  = sext12(instr[31:20]);
         end
         default: begin
            dec.iclass  = CLS_ILLEGAL;
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage. Decodes each accepted fetch word and holds it
// in a two-entry skid buffer (main + skid) so every output, in_ready included,
// comes straight from a flop while still sustaining one word per cycle.
// Only XLEN = 32 is meaningful.
module rv32i_decode_stage
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [11:0]     out_imm12,
   output logic [XLEN-1:0] out_imm32,
   output logic [3:0]      out_class,
   output logic            out_illegal
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   skid_state_e state;
   skid_state_e state_next;

   decoded_t dec_fields;
   decoded_t dec_in;
   decoded_t main_q;
   decoded_t skid_q;

   logic in_ready_q;
   logic out_valid_q;
   logic accept;
   logic take;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   rv32i_field_decode u_field_decode (
      .instr (in_instr),
      .dec   (dec_fields)
   );

   // Attach the incoming PC to the freshly decoded fields
   always_comb begin
      dec_in    = dec_fields;
      dec_in.pc = in_pc;
   end

   assign accept = in_valid & in_ready_q;
   assign take   = out_valid_q & out_ready;

   // State register plus the registered handshake outputs, derived from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_next;
         in_ready_q  <= (state_next != ST_TWO);
         out_valid_q <= (state_next != ST_EMPTY);
      end
   end

   // Next-state and register-load decisions; flush overrides everything and drops any accept
   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_next   = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && !take) begin
                  state_next = ST_TWO;
                  load_skid  = 1'b1;
               end else if (!accept && take) begin
                  state_next = ST_EMPTY;
               end else if (accept && take) begin
                  load_main_in = 1'b1;
               end
            end
            ST_TWO: begin
               if (take) begin
                  state_next     = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // Main and skid data registers; main holds what execute currently sees
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= dec_in;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec_in;
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = main_q.pc;
   assign out_opcode  = main_q.opcode;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_imm12   = main_q.imm12;
   assign out_imm32   = main_q.imm32;
   assign out_class   = main_q.iclass;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: a table of hand-encoded words,
// hand-written backpressure/flush/reset sequences, and a randomized run
// scored against an occupancy-queue model with an arithmetic reference decoder.
module tb_rv32i_decode_stage;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [11:0] out_imm12;
   logic [31:0] out_imm32;
   logic [3:0]  out_class;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;

   rv32i_decode_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_opcode  (out_opcode),
      .out_funct3  (out_funct3),
      .out_funct7  (out_funct7),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_imm12   (out_imm12),
      .out_imm32   (out_imm32),
      .out_class   (out_class),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  cls;
      logic        ill;
      logic [31:0] imm32;
      logic [11:0] imm12;
   } vec_t;

   typedef struct {
      logic [3:0]  cls;
      logic        ill;
      logic [31:0] imm32;
      logic [11:0] imm12;
   } ref_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decoder: immediates built by weighting bits and subtracting the sign weight
   function automatic ref_t ref_decode(input logic [31:0] w);
      ref_t        r;
      int unsigned i_imm, s_imm, b_imm, u_imm, j_imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      f3 = w[14:12];
      f7 = w[31:25];
      i_imm = w[31:20];
      if (w[31]) i_imm = i_imm - 4096;
      s_imm = w[31:25] * 32 + w[11:7];
      if (w[31]) s_imm = s_imm - 4096;
      b_imm = w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
      if (w[31]) b_imm = b_imm - 4096;
      u_imm = w[31:12] * 4096;
      j_imm = w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
      if (w[31]) j_imm = j_imm - 1048576;
      r.cls   = 4'd0;
      r.ill   = 1'b0;
      r.imm32 = 32'd0;
      r.imm12 = 12'd0;
      case (w[6:0])
         7'h13: begin
            r.cls = CLS_OP_IMM; r.imm32 = i_imm; r.imm12 = w[31:20];
            r.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         end
         7'h33: begin r.cls = CLS_OP; r.ill = (f7 != 7'h00 && f7 != 7'h20); end
         7'h03: begin r.cls = CLS_LOAD; r.imm32 = i_imm; r.imm12 = w[31:20]; end
         7'h23: begin r.cls = CLS_STORE; r.imm32 = s_imm; end
         7'h63: begin r.cls = CLS_BRANCH; r.imm32 = b_imm; end
         7'h6F: begin r.cls = CLS_JAL; r.imm32 = j_imm; end
         7'h67: begin r.cls = CLS_JALR; r.imm32 = i_imm; r.imm12 = w[31:20]; r.ill = (f3 != 3'd0); end
         7'h37: begin r.cls = CLS_LUI; r.imm32 = u_imm; end
         7'h17: begin r.cls = CLS_AUIPC; r.imm32 = u_imm; end
         7'h0F: begin r.cls = CLS_MISC_MEM; end
         7'h73: begin r.cls = CLS_SYSTEM; r.imm32 = i_imm; r.imm12 = w[31:20]; end
         default: begin r.cls = CLS_ILLEGAL; r.ill = 1'b1; end
      endcase
      return r;
   endfunction

   // Compare every output field against the expected word and pc
   task automatic check_decoded(input string tag, input logic [31:0] w, input logic [31:0] pc);
      ref_t r;
      r = ref_decode(w);
      check_output({tag, ".pc"},      out_pc,      pc);
      check_output({tag, ".opcode"},  out_opcode,  w[6:0]);
      check_output({tag, ".funct3"},  out_funct3,  w[14:12]);
      check_output({tag, ".funct7"},  out_funct7,  w[31:25]);
      check_output({tag, ".rd"},      out_rd,      w[11:7]);
      check_output({tag, ".rs1"},     out_rs1,     w[19:15]);
      check_output({tag, ".rs2"},     out_rs2,     w[24:20]);
      check_output({tag, ".imm12"},   out_imm12,   r.imm12);
      check_output({tag, ".imm32"},   out_imm32,   r.imm32);
      check_output({tag, ".class"},   out_class,   r.cls);
      check_output({tag, ".illegal"}, out_illegal, r.ill);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      logic [6:0]  opc [11];
      int          k;
      opc = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
      w = $urandom;
      k = $urandom_range(0, 13);
      if (k < 11) w[6:0] = opc[k];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return w;
   endfunction

   vec_t        vecs [$];
   entry_t      q [$];
   logic [31:0] got [$];
   int          got_cyc [$];

   initial begin
      logic        c_sent;
      logic        exp_take;
      logic        exp_accept;
      logic [31:0] pc_ctr;

      // Hand-encoded words with hand-derived class/illegal/imm32/imm12
      vecs.push_back('{32'hFFF08293, CLS_OP_IMM,   1'b0, 32'hFFFFFFFF, 12'hFFF});
      vecs.push_back('{32'h40415193, CLS_OP_IMM,   1'b0, 32'h00000404, 12'h404});
      vecs.push_back('{32'h40111093, CLS_OP_IMM,   1'b1, 32'h00000401, 12'h401});
      vecs.push_back('{32'h123452B7, CLS_LUI,      1'b0, 32'h12345000, 12'h000});
      vecs.push_back('{32'h00000000, CLS_ILLEGAL,  1'b1, 32'h00000000, 12'h000});
      vecs.push_back('{32'hFE20AE23, CLS_STORE,    1'b0, 32'hFFFFFFFC, 12'h000});
      vecs.push_back('{32'hFE208CE3, CLS_BRANCH,   1'b0, 32'hFFFFFFF8, 12'h000});
      vecs.push_back('{32'h001000EF, CLS_JAL,      1'b0, 32'h00000800, 12'h000});
      vecs.push_back('{32'h00009067, CLS_JALR,     1'b1, 32'h00000000, 12'h000});
      vecs.push_back('{32'h00C280E7, CLS_JALR,     1'b0, 32'h0000000C, 12'h00C});
      vecs.push_back('{32'h402081B3, CLS_OP,       1'b0, 32'h00000000, 12'h000});
      vecs.push_back('{32'h022081B3, CLS_OP,       1'b1, 32'h00000000, 12'h000});
      vecs.push_back('{32'h80000097, CLS_AUIPC,    1'b0, 32'h80000000, 12'h000});
      vecs.push_back('{32'h00000073, CLS_SYSTEM,   1'b0, 32'h00000000, 12'h000});
      vecs.push_back('{32'h0FF0000F, CLS_MISC_MEM, 1'b0, 32'h00000000, 12'h000});
      vecs.push_back('{32'h80013093, CLS_OP_IMM,   1'b0, 32'hFFFFF800, 12'h800});
      vecs.push_back('{32'hFFFFFFFF, CLS_ILLEGAL,  1'b1, 32'h00000000, 12'h000});

      // Reset state, observed before the first clock edge
      rst = 1'b1;
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      check_output("reset.out_valid", out_valid, 1'b0);
      check_output("reset.in_ready",  in_ready,  1'b1);
      check_output("reset.out_pc",    out_pc,    32'h0);
      check_output("reset.out_imm32", out_imm32, 32'h0);
      check_output("reset.out_class", out_class, 4'd0);
      #10;
      rst = 1'b0;
      tick();

      // Table: one word per pass, checked the cycle after acceptance
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(1'b1, vecs[i].instr, 32'h1000 + i * 4, 1'b1, 1'b0);
         tick();
         apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         check_output($sformatf("vec%0d.out_valid", i), out_valid, 1'b1);
         check_output($sformatf("vec%0d.pc", i), out_pc, 32'h1000 + i * 4);
         check_output($sformatf("vec%0d.opcode", i), out_opcode, vecs[i].instr[6:0]);
         check_output($sformatf("vec%0d.rd", i), out_rd, vecs[i].instr[11:7]);
         check_output($sformatf("vec%0d.rs1", i), out_rs1, vecs[i].instr[19:15]);
         check_output($sformatf("vec%0d.rs2", i), out_rs2, vecs[i].instr[24:20]);
         check_output($sformatf("vec%0d.funct3", i), out_funct3, vecs[i].instr[14:12]);
         check_output($sformatf("vec%0d.funct7", i), out_funct7, vecs[i].instr[31:25]);
         check_output($sformatf("vec%0d.class", i), out_class, vecs[i].cls);
         check_output($sformatf("vec%0d.illegal", i), out_illegal, vecs[i].ill);
         check_output($sformatf("vec%0d.imm32", i), out_imm32, vecs[i].imm32);
         check_output($sformatf("vec%0d.imm12", i), out_imm12, vecs[i].imm12);
      end
      tick();
      check_output("drain.out_valid", out_valid, 1'b0);

      // Backpressure: A and B fill the buffer, C is held off
      apply_stimulus(1'b1, 32'h00100093, 32'h2000, 1'b0, 1'b0);
      tick();
      check_output("bp.after_a.in_ready", in_ready, 1'b1);
      check_output("bp.after_a.out_pc",   out_pc,   32'h2000);
      apply_stimulus(1'b1, 32'h00200113, 32'h2004, 1'b0, 1'b0);
      tick();
      check_output("bp.after_b.in_ready", in_ready, 1'b0);
      check_output("bp.after_b.out_pc",   out_pc,   32'h2000);
      apply_stimulus(1'b1, 32'h00300193, 32'h2008, 1'b0, 1'b0);
      tick();
      check_output("bp.hold.in_ready", in_ready, 1'b0);
      check_output("bp.hold.out_pc",   out_pc,   32'h2000);
      c_sent = 1'b0;
      for (int k = 0; k < 6; k++) begin
         apply_stimulus(!c_sent, 32'h00300193, 32'h2008, 1'b1, 1'b0);
         @(negedge clk);
         if (out_valid) begin
            got.push_back(out_pc);
            got_cyc.push_back(k);
         end
         if (!c_sent && in_ready) c_sent = 1'b1;
         tick();
      end
      check_output("bp.count", got.size(), 3);
      if (got.size() == 3) begin
         check_output("bp.order0", got[0], 32'h2000);
         check_output("bp.order1", got[1], 32'h2004);
         check_output("bp.order2", got[2], 32'h2008);
         check_output("bp.consecutive", got_cyc[2] - got_cyc[0], 2);
      end

      // Flush while full, with a word on the input
      apply_stimulus(1'b1, 32'h00100093, 32'h3000, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h00200113, 32'h3004, 1'b0, 1'b0);
      tick();
      check_output("fl.full.in_ready", in_ready, 1'b0);
      apply_stimulus(1'b1, 32'h00300193, 32'h3008, 1'b0, 1'b1);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_output("fl.two.out_valid", out_valid, 1'b0);
      check_output("fl.two.in_ready",  in_ready,  1'b1);
      // Flush in ONE with a same-cycle accept: that word must be dropped
      apply_stimulus(1'b1, 32'h00400213, 32'h300C, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h00500293, 32'h3010, 1'b0, 1'b1);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_output("fl.one.out_valid", out_valid, 1'b0);
      check_output("fl.one.in_ready",  in_ready,  1'b1);
      tick();
      check_output("fl.dropped.out_valid", out_valid, 1'b0);

      // Asynchronous reset between edges with one valid entry
      apply_stimulus(1'b1, 32'h00600313, 32'h4000, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_output("rst.pre.out_valid", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_output("rst.async.out_valid", out_valid, 1'b0);
      check_output("rst.async.in_ready",  in_ready,  1'b1);
      check_output("rst.async.out_pc",    out_pc,    32'h0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      apply_stimulus(1'b1, 32'h00700393, 32'h4004, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_output("rst.after.out_valid", out_valid, 1'b1);
      check_output("rst.after.out_pc",    out_pc,    32'h4004);
      tick();

      // Randomized traffic against the occupancy-queue model
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      q.delete();
      pc_ctr = 32'h8000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         apply_stimulus($urandom_range(0, 9) < 7, gen_instr(), pc_ctr,
                        $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
         @(negedge clk);
         check_output("rnd.out_valid", out_valid, q.size() > 0);
         check_output("rnd.in_ready",  in_ready,  q.size() < 2);
         if (q.size() > 0) check_decoded("rnd", q[0].instr, q[0].pc);
         exp_take   = (q.size() > 0) && out_ready;
         exp_accept = in_valid && (q.size() < 2);
         if (flush) begin
            q.delete();
         end else begin
            if (exp_take) void'(q.pop_front());
            if (exp_accept) begin
               q.push_back('{in_instr, in_pc});
               pc_ctr = pc_ctr + 4;
            end
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Pipelined RV32I instruction decoder between fetch and execute. Takes raw 32-bit instruction words over a valid/ready handshake. Splits each word into the opcode, funct3, immediate and register fields that the execute units (including the I-type ALU) consume, and adds a class tag and an illegal flag. A 2-entry skid buffer registers every output, including `in_ready`, and sustains one instruction per cycle under backpressure.

## Interface
- `XLEN`, 32, datapath and PC width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous; discards all buffered instructions.
- `in_valid` in 1: fetch word present.
- `in_ready` out 1: stage can accept; registered.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: PC of `in_instr`.
- `out_valid` out 1: decoded instruction present.
- `out_ready` in 1: execute accepts.
- `out_pc` out 32: passed through unchanged.
- `out_opcode` out 7: `instr[6:0]`.
- `out_funct3` out 3: `instr[14:12]`.
- `out_funct7` out 7: `instr[31:25]`.
- `out_rd` out 5, `out_rs1` out 5, `out_rs2` out 5: `instr[11:7]`, `instr[19:15]`, `instr[24:20]`.
- `out_imm12` out 12: `instr[31:20]` for classes OP_IMM, LOAD, JALR and SYSTEM; 0 for all other classes.
- `out_imm32` out 32: sign-extended immediate for the format.
- `out_class` out 4: `iclass_e` value.
- `out_illegal` out 1: word is not a legal RV32I encoding.

## Operation
- Opcode to class mapping:
  - 0x13 OP_IMM, 0x33 OP, 0x03 LOAD, 0x23 STORE, 0x63 BRANCH.
  - 0x6F JAL, 0x67 JALR, 0x37 LUI, 0x17 AUIPC.
  - 0x0F MISC_MEM, 0x73 SYSTEM.
  - Any other opcode: class ILLEGAL and `illegal=1`.
- Immediate formation for `out_imm32`:
  - I format (OP_IMM, LOAD, JALR, SYSTEM): sext `instr[31:20]`.
  - S format: sext {`instr[31:25]`, `instr[11:7]`}.
  - B format: sext {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
  - U format: {`instr[31:12]`, 12'h000}.
  - J format: sext {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
  - OP and MISC_MEM: 0.
- Exception: OP_IMM with funct3 011 (sltiu) still outputs the sign-extended value. Execute is responsible for treating it as unsigned.
- Additional illegal conditions:
  - OP_IMM with funct3=001 and funct7≠0000000.
  - OP_IMM with funct3=101 and funct7 ∉ {0000000, 0100000}.
  - OP with funct7 ∉ {0000000, 0100000}.
  - JALR with funct3≠000.
- Illegal words still flow through the pipe with all fields populated. Execute raises the trap.
- Skid buffer: a main output register plus a skid register. Define `accept = in_valid & in_ready` and `take = out_valid & out_ready`.
- State EMPTY (`out_valid=0`, `in_ready=1`):
  - On `accept`, go to ONE.
- State ONE (`out_valid=1`, `in_ready=1`):
  - `accept & !take`: write the skid register, go to TWO.
  - `!accept & take`: go to EMPTY.
  - `accept & take`: load the main register with the new word, stay in ONE.
- State TWO (`out_valid=1`, `in_ready=0`):
  - On `take`, move skid to main and go to ONE.
- `flush` has priority over all of the above: next state EMPTY, and a same-cycle `accept` is dropped.
- Ordering is strictly FIFO. No word is lost or duplicated.

## Timing
- Latency: 1 cycle from `accept` to `out_valid`, when the stage is EMPTY or ONE with a simultaneous take.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- `in_ready` is registered and equals "state ≠ TWO".
- Output fields are stable while `out_valid & !out_ready`.
- Reset (asynchronous, takes effect immediately without a clock edge):
  - State goes to EMPTY.
  - `out_valid=0`, `in_ready=1`.
  - All data outputs go to 0 and `out_class` to ILLEGAL encoding 0.
- Reset asserted mid-stream discards all buffered words.
- Flush: `out_valid=0` and `in_ready=1` from the cycle after `flush` is sampled.

## Structure
- Shared package `rv32_pkg` holds:
  - opcode localparams (`OPC_OP_IMM` etc.),
  - `iclass_e` (4-bit enum; ILLEGAL=0),
  - `decoded_t` packed struct carrying all `out_*` fields except valid.
- Sub-module `rv32i_field_decode` is purely combinational: `instr` in, `decoded_t` out. The top level holds the FSM and two `decoded_t` registers.

## Test plan
- addi x5,x1,-1, `in_instr`=0xFFF08293 → next cycle: opcode 0x13, rd 5, rs1 1, funct3 0, imm12 0xFFF, imm32 0xFFFFFFFF, class OP_IMM, illegal 0.
- srai x3,x2,4, 0x40415193 → funct3 5, funct7 0x20, imm12 0x404, illegal 0. Then 0x40111093 (slli with funct7 0x20) → illegal 1.
- lui x5,0x12345, 0x123452B7 → class LUI, imm32 0x12345000, imm12 0. Word 0x00000000 → class ILLEGAL, illegal 1.
- Backpressure: `out_ready=0`, drive 3 back-to-back words A, B, C → A and B accepted, `in_ready`=0 the cycle after B, C held. Then `out_ready=1` → A, B, C delivered in order on consecutive cycles, no duplicates.
- Flush while in TWO with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, and the flush-cycle input never appears at the output.
- Assert `rst` between clock edges with ONE valid entry → `out_valid` drops immediately without waiting for a clock edge. After release, the first accepted word emerges after 1 cycle.
